dlx_mem_responder: RTL and testbench

Word-addressed memory slave: the responder end of the DLX control unit's MR/MW/BUSY memory handshake. Services instruction fetches, loads and stores from the datapath with a programmable wait-state count. Provides a host debug write port for program loading while the core sits in INIT. Sits between the DLX datapath (MAR/MDR/IR) and an internal RAM array.

---
 rtl/dlx_mem_pkg.sv | 26 ++
 rtl/dlx_mem_responder_if.sv | 30 +++
 rtl/dlx_mem_lfsr.sv | 19 +
 rtl/dlx_mem_responder.sv | 114 +++++++++++
 tb/tb_dlx_mem_responder.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/dlx_mem_pkg.sv
// dlx_mem_pkg: shared constants and types for the DLX memory responder.
//   state_t    : responder FSM encoding (IDLE / ACCESS)
//   WORD_W     : data word width
//   CNT_W      : wait counter width (one bit wider with DLX_MEM_RAND_WAIT_EN)
//   LFSR_SEED / LFSR_TAPS : random wait-state generator constants
package dlx_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

`ifdef DLX_MEM_RAND_WAIT_EN
  // Worst case WAIT_STATES-1+3 = 17 needs 5 bits.
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 -> state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dlx_mem_responder_if.sv
// dlx_mem_responder_if: core MR/MW/BUSY handshake plus host debug write port.
//   master : control unit / datapath / host side (drives requests)
//   slave  : memory responder side (drives DOUT, BUSY, DBG_ACK, ERR)
interface dlx_mem_responder_if
  import dlx_mem_pkg::*;
#(
  parameter int ADDR_W = 10
);
  logic              MR;
  logic              MW;
  logic [31:0]       ADDR;
  logic [WORD_W-1:0] DIN;
  logic [WORD_W-1:0] DOUT;
  logic              BUSY;
  logic              DBG_WE;
  logic [ADDR_W-1:0] DBG_ADDR;
  logic [WORD_W-1:0] DBG_DIN;
  logic              DBG_ACK;
  logic              ERR;

  modport master (
    output MR, MW, ADDR, DIN, DBG_WE, DBG_ADDR, DBG_DIN,
    input  DOUT, BUSY, DBG_ACK, ERR
  );

  modport slave (
    input  MR, MW, ADDR, DIN, DBG_WE, DBG_ADDR, DBG_DIN,
    output DOUT, BUSY, DBG_ACK, ERR
  );
endinterface

// File: rtl/dlx_mem_lfsr.sv
// dlx_mem_lfsr: 16-bit Fibonacci LFSR used to randomize wait states.
//   clk, rst_n : clock, async active-low reset (loads LFSR_SEED)
//   en         : advance one step
//   state      : current LFSR value
module dlx_mem_lfsr
  import dlx_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state <= LFSR_SEED;
    else if (en) state <= {state[14:0], ^(state & LFSR_TAPS)};
  end

endmodule

// File: rtl/dlx_mem_responder.sv
// dlx_mem_responder: word-addressed memory slave answering the DLX control
// unit's MR/MW/BUSY handshake with a programmable wait-state count, plus a
// host debug write port for program loading while the core is idle.
//   CLK, RESET_N : clock, async active-low reset (RAM contents not reset)
//   bus          : dlx_mem_responder_if.slave (MR/MW/ADDR/DIN/DOUT/BUSY,
//                  DBG_WE/DBG_ADDR/DBG_DIN/DBG_ACK, ERR)
// Optional: define DLX_MEM_RAND_WAIT_EN to add 0..3 pseudo-random extra
// wait states per access.
module dlx_mem_responder
  import dlx_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
)(
  input  logic CLK,
  input  logic RESET_N,
  dlx_mem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait
    $error("dlx_mem_responder: WAIT_STATES must be 1..15");
  end

  logic [WORD_W-1:0] mem [DEPTH];

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, wait_init;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] din_q, dout_q;
  logic              wr_q, err_q;

  logic accept, abort, done, commit, busy, dbg_ack, err_d, req;

  // Upper address bits are deliberately ignored (address wraps).
  logic unused_addr;
  assign unused_addr = ^bus.ADDR[31:ADDR_W];

`ifdef DLX_MEM_RAND_WAIT_EN
  logic [15:0] lfsr;
  logic        unused_lfsr;
  dlx_mem_lfsr u_lfsr (.clk(CLK), .rst_n(RESET_N), .en(accept), .state(lfsr));
  assign wait_init   = CNT_W'(WAIT_STATES - 1) + CNT_W'(lfsr[1:0]);
  assign unused_lfsr = ^lfsr[15:2];
`else
  assign wait_init = CNT_W'(WAIT_STATES - 1);
`endif

  // Next-state / handshake decode.
  always_comb begin
    req     = bus.MR | bus.MW;
    accept  = 1'b0;
    abort   = 1'b0;
    done    = 1'b0;
    dbg_ack = 1'b0;
    state_d = state;
    case (state)
      IDLE: begin
        accept  = req;
        dbg_ack = !req && bus.DBG_WE;
        if (req) state_d = ACCESS;
      end
      ACCESS: begin
        // Master must hold its request while BUSY; dropping it aborts.
        abort = (cnt != '0) && !req;
        done  = (cnt == '0);
        if (abort || done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy   = accept || (state == ACCESS && cnt != '0);
    commit = done && wr_q;
    err_d  = (accept && bus.MR && bus.MW) || abort;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      din_q  <= '0;
      wr_q   <= 1'b0;
      dout_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_d;
      err_q <= err_d;
      if (accept) begin
        addr_q <= bus.ADDR[ADDR_W-1:0];
        din_q  <= bus.DIN;
        wr_q   <= bus.MW;   // MR&&MW is serviced as a write
        cnt    <= wait_init;
        dout_q <= mem[bus.ADDR[ADDR_W-1:0]];
      end else if (state == ACCESS && cnt != '0) begin
        cnt    <= cnt - 1'b1;
        dout_q <= mem[addr_q];
      end
    end
  end

  // RAM: debug writes only happen in IDLE, core commits only leaving ACCESS,
  // so the two never collide.
  always_ff @(posedge CLK) begin
    if (dbg_ack)     mem[bus.DBG_ADDR] <= bus.DBG_DIN;
    else if (commit) mem[addr_q]       <= din_q;
  end

  assign bus.BUSY    = busy;
  assign bus.DOUT    = dout_q;
  assign bus.DBG_ACK = dbg_ack;
  assign bus.ERR     = err_q;

endmodule

// File: tb/tb_dlx_mem_responder.sv
// tb_dlx_mem_responder: directed self-checking bench for dlx_mem_responder
// (ADDR_W=10, WAIT_STATES=2). Inputs change on the falling edge and outputs
// are sampled 1 time unit later.
module tb_dlx_mem_responder;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  dlx_mem_responder_if #(.ADDR_W(10)) bus ();

  dlx_mem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut (
    .CLK(clk), .RESET_N(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and set core request inputs.
  task automatic req(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.MR = mr; bus.MW = mw; bus.ADDR = a; bus.DIN = d;
    #1;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b1;
    bus.MR = 0; bus.MW = 0; bus.ADDR = '0; bus.DIN = '0;
    bus.DBG_WE = 0; bus.DBG_ADDR = '0; bus.DBG_DIN = '0;

    // Async reset asserted mid-cycle, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, bus.BUSY}, 32'd0);
    chk("rst_dout", bus.DOUT, 32'd0);
    chk("rst_err",  {31'b0, bus.ERR},  32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Debug load: addr 3 and addr 9.
    @(negedge clk);
    bus.DBG_WE = 1; bus.DBG_ADDR = 10'd3; bus.DBG_DIN = 32'h20010005; #1;
    chk("dbg_ack_hi", {31'b0, bus.DBG_ACK}, 32'd1);
    @(negedge clk);
    bus.DBG_ADDR = 10'd9; bus.DBG_DIN = 32'h55AA0009; #1;
    chk("dbg_ack_hi2", {31'b0, bus.DBG_ACK}, 32'd1);
    @(negedge clk);
    bus.DBG_WE = 0; #1;
    chk("dbg_ack_lo", {31'b0, bus.DBG_ACK}, 32'd0);

    // Fetch addr 3; a concurrent debug write must lose.
    @(negedge clk);
    bus.MR = 1; bus.ADDR = 32'd3;
    bus.DBG_WE = 1; bus.DBG_ADDR = 10'd3; bus.DBG_DIN = 32'hFFFFFFFF; #1;
    chk("fetch_c0_busy", {31'b0, bus.BUSY}, 32'd1);
    chk("fetch_dbg_nack", {31'b0, bus.DBG_ACK}, 32'd0);
    @(negedge clk); bus.DBG_WE = 0; #1;
    chk("fetch_c1_busy", {31'b0, bus.BUSY}, 32'd1);
    @(negedge clk); #1;
    chk("fetch_c2_busy", {31'b0, bus.BUSY}, 32'd0);
    chk("fetch_c2_dout", bus.DOUT, 32'h20010005);
    req(0, 0, 32'd0, 32'd0);
    chk("idle_busy", {31'b0, bus.BUSY}, 32'd0);
    chk("dout_hold", bus.DOUT, 32'h20010005);

    // Store addr 7 then fetch addr 7 with no idle gap.
    req(0, 1, 32'd7, 32'hDEADBEEF);
    chk("st_c0_busy", {31'b0, bus.BUSY}, 32'd1);
    req(0, 1, 32'd7, 32'hDEADBEEF);
    req(0, 1, 32'd7, 32'hDEADBEEF);
    chk("st_c2_busy", {31'b0, bus.BUSY}, 32'd0);
    req(1, 0, 32'd7, 32'd0);
    chk("b2b_busy", {31'b0, bus.BUSY}, 32'd1);
    req(1, 0, 32'd7, 32'd0);
    req(1, 0, 32'd7, 32'd0);
    chk("b2b_c2_busy", {31'b0, bus.BUSY}, 32'd0);
    chk("b2b_dout", bus.DOUT, 32'hDEADBEEF);
    chk("b2b_err", {31'b0, bus.ERR}, 32'd0);
    req(0, 0, 32'd0, 32'd0);

    // Reset in the middle of a store: write must not commit.
    req(0, 1, 32'd9, 32'h00001234);
    @(negedge clk);
    rst_n = 1'b0; bus.MW = 0; #1;
    chk("rst_mid_busy", {31'b0, bus.BUSY}, 32'd0);
    chk("rst_mid_dout", bus.DOUT, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    req(1, 0, 32'd9, 32'd0);
    req(1, 0, 32'd9, 32'd0);
    req(1, 0, 32'd9, 32'd0);
    chk("rst_mid_rd", bus.DOUT, 32'h55AA0009);
    req(0, 0, 32'd0, 32'd0);

    // MR and MW together: ERR pulse, serviced as a write.
    req(1, 1, 32'h0A, 32'hCAFEF00D);
    req(1, 1, 32'h0A, 32'hCAFEF00D);
    chk("rw_err_hi", {31'b0, bus.ERR}, 32'd1);
    req(1, 1, 32'h0A, 32'hCAFEF00D);
    chk("rw_err_lo", {31'b0, bus.ERR}, 32'd0);
    req(1, 0, 32'h0A, 32'd0);
    req(1, 0, 32'h0A, 32'd0);
    req(1, 0, 32'h0A, 32'd0);
    chk("rw_rd", bus.DOUT, 32'hCAFEF00D);
    req(0, 0, 32'd0, 32'd0);

    // Request dropped in cycle 1: abort, ERR pulse, back to IDLE.
    req(1, 0, 32'd3, 32'd0);
    req(0, 0, 32'd3, 32'd0);
    req(0, 0, 32'd3, 32'd0);
    chk("drop_busy", {31'b0, bus.BUSY}, 32'd0);
    chk("drop_err_hi", {31'b0, bus.ERR}, 32'd1);
    @(negedge clk);
    bus.DBG_WE = 1; bus.DBG_ADDR = 10'd20; bus.DBG_DIN = 32'h1; #1;
    chk("drop_err_lo", {31'b0, bus.ERR}, 32'd0);
    chk("drop_idle_ack", {31'b0, bus.DBG_ACK}, 32'd1);
    @(negedge clk); bus.DBG_WE = 0;

    // Address wrap: 0x405 aliases word 5.
    req(0, 1, 32'h00000405, 32'h0BADC0DE);
    req(0, 1, 32'h00000405, 32'h0BADC0DE);
    req(0, 1, 32'h00000405, 32'h0BADC0DE);
    req(1, 0, 32'd5, 32'd0);
    req(1, 0, 32'd5, 32'd0);
    req(1, 0, 32'd5, 32'd0);
    chk("wrap_rd", bus.DOUT, 32'h0BADC0DE);
    req(0, 0, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
